cdtimer_multi: RTL and testbench
================================

Name: cdtimer_multi

Overview:
- Multi-channel countdown timer; parametrised successor to the single-channel prescaled countdown timer.
- NUM_CH independent channels, each with its own prescaler phase, a runtime-programmable shared divisor, one-shot or auto-reload mode, per-channel run gating, sticky timeout flags with explicit clear, and a combined interrupt.
- Sits on the CPU peripheral side. Software writes a channel's count, polls the counter through a read port, and services `irq`.

Parameters:
- NUM_CH, 4: number of channels (>=1).
- WIDTH, 16: counter/data width.
- PRESC_WIDTH, 16: width of the prescaler divisor and of each channel's phase counter.
- CH_W, $clog2(NUM_CH) (min 1): channel index width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- presc_div  in  PRESC_WIDTH  shared divisor; one tick per presc_div+1 enabled cycles.
- wr  in  1  write strobe.
- wr_ch  in  CH_W  channel targeted by wr.
- wr_data  in  WIDTH  initial count, also the reload value.
- wr_auto  in  1  mode written with wr: 1 = auto-reload, 0 = one-shot.
- run  in  NUM_CH  per-channel enable.
- clr_timeout  in  NUM_CH  per-channel timeout clear.
- irq_en  in  NUM_CH  per-channel interrupt mask.
- rd_ch  in  CH_W  channel selected for readback.
- rd_count  out  WIDTH  combinational count of channel rd_ch.
- timeout  out  NUM_CH  sticky timeout flags.
- irq  out  1  OR of (timeout & irq_en), registered.

Behaviour:
- Per-channel state: count[WIDTH], reload[WIDTH], auto, phase[PRESC_WIDTH], timeout.
- Reset (rst=0, asynchronous): all state is 0, irq=0. Outputs follow immediately. Deassertion is used synchronously.
- Write (wr=1, target channel ch=wr_ch):
  - count<=wr_data, reload<=wr_data, auto<=wr_auto, phase<=0, timeout<=0.
  - Write beats tick and clr in the same cycle. The write ignores run.
  - wr_ch>=NUM_CH: no effect.
- Prescaler (channel not being written, run[i]=1):
  - phase>=presc_div: phase<=0, tick. The >= covers presc_div being lowered below phase.
  - Otherwise phase<=phase+1.
  - presc_div=0 gives a tick every enabled cycle.
  - run[i]=0: phase and count hold; timeout and clr still operate.
- Tick:
  - count>1: count<=count-1.
  - count==1: timeout<=1; count<=auto ? reload : 0.
  - count==0: no change, no timeout. The phase keeps cycling. Auto-reload with reload=0 never fires.
- Latency: with presc_div=P, a write of N (N>=1) sets timeout N*(P+1) enabled cycles after the write edge. Example: P=2, N=2: count stays 2 for 3 cycles, 1 for 3 cycles, then timeout=1 with count=0 (one-shot).
- clr_timeout[i]=1 clears timeout, except that a timeout set in the same cycle wins and the flag stays 1.
- irq is registered: irq<=|(timeout_next & irq_en). It rises the same edge timeout sets if the channel is enabled. Masking drops irq on the next edge.
- Channels are fully independent. Simultaneous ticks on several channels are all honoured.
- Counts never wrap below 0. No arithmetic overflow is possible: the phase compare uses >=.

Test Plan:
- Reset mid-count (ch0 loaded 5, P=2, run=1), assert rst -> rd_count, timeout and irq read 0 immediately (asynchronous) and stay 0 until a new write.
- P=2, write ch0=2 one-shot, run[0]=1 -> count is 2,2,2,1,1,1, then 0 with timeout[0]=1; the flag holds across further periods; phase cycles 0,1,2.
- Write ch1=3 auto, P=0 -> count 3,2,1,3,2,1…; timeout[1] sets on the first 1->reload; clr_timeout[1] asserted on a later expiry cycle -> flag stays 1; asserted on a non-expiry cycle -> flag 0.
- Reload mid-period: ch0=5 at P=2; when phase=1, write ch0=10 -> count=10, phase=0, timeout=0; the first decrement occurs 3 cycles later.
- After ch2 expires (timeout=1), write ch2=0 -> timeout=0; after 2+ full periods, count is still 0 and timeout stays 0.
- Isolation/gating: ch0 and ch3 loaded 4, run=4'b0001 -> ch3 holds 4 while ch0 expires. Toggle run[3] -> ch3 resumes from its held phase. irq_en=4'b1000 -> irq=0 on the ch0 expiry and 1 on the ch3 expiry.

Source files
------------

// File: rtl/cdtimer_multi.sv
// Multi-channel prescaled countdown timer with a shared divisor, per-channel
// one-shot/auto-reload modes, sticky timeout flags and a masked, registered irq.
module cdtimer_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned PRESC_WIDTH = 16,
    parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PRESC_WIDTH-1:0] presc_div,
    input  logic                   wr,
    input  logic [CH_W-1:0]        wr_ch,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_auto,
    input  logic [NUM_CH-1:0]      run,
    input  logic [NUM_CH-1:0]      clr_timeout,
    input  logic [NUM_CH-1:0]      irq_en,
    input  logic [CH_W-1:0]        rd_ch,
    output logic [WIDTH-1:0]       rd_count,
    output logic [NUM_CH-1:0]      timeout,
    output logic                   irq
);

    logic [WIDTH-1:0]       count_q  [NUM_CH];
    logic [WIDTH-1:0]       count_d  [NUM_CH];
    logic [WIDTH-1:0]       reload_q [NUM_CH];
    logic [WIDTH-1:0]       reload_d [NUM_CH];
    logic [PRESC_WIDTH-1:0] phase_q  [NUM_CH];
    logic [PRESC_WIDTH-1:0] phase_d  [NUM_CH];
    logic [NUM_CH-1:0]      auto_q;
    logic [NUM_CH-1:0]      auto_d;
    logic [NUM_CH-1:0]      timeout_q;
    logic [NUM_CH-1:0]      timeout_d;
    logic                   irq_q;
    logic                   irq_d;

    // Per-channel next state: a write overrides tick and clear on its channel.
    always_comb begin
        count_d   = count_q;
        reload_d  = reload_q;
        phase_d   = phase_q;
        auto_d    = auto_q;
        timeout_d = timeout_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            logic wr_hit;
            logic tick;
            logic expire;
            wr_hit = wr && (32'(wr_ch) == i);
            tick   = 1'b0;
            expire = 1'b0;
            if (wr_hit) begin
                count_d[i]   = wr_data;
                reload_d[i]  = wr_data;
                auto_d[i]    = wr_auto;
                phase_d[i]   = '0;
                timeout_d[i] = 1'b0;
            end else begin
                if (run[i]) begin
                    // >= keeps the phase bounded when the divisor is lowered.
                    if (phase_q[i] >= presc_div) begin
                        phase_d[i] = '0;
                        tick       = 1'b1;
                    end else begin
                        phase_d[i] = phase_q[i] + PRESC_WIDTH'(1);
                    end
                end
                if (tick) begin
                    if (count_q[i] > WIDTH'(1)) begin
                        count_d[i] = count_q[i] - WIDTH'(1);
                    end else if (count_q[i] == WIDTH'(1)) begin
                        expire     = 1'b1;
                        count_d[i] = auto_q[i] ? reload_q[i] : '0;
                    end
                end
                if (clr_timeout[i]) begin
                    timeout_d[i] = 1'b0;
                end
                if (expire) begin
                    timeout_d[i] = 1'b1;
                end
            end
        end
        irq_d = |(timeout_d & irq_en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                count_q[i]  <= '0;
                reload_q[i] <= '0;
                phase_q[i]  <= '0;
            end
            auto_q    <= '0;
            timeout_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            reload_q  <= reload_d;
            phase_q   <= phase_d;
            auto_q    <= auto_d;
            timeout_q <= timeout_d;
            irq_q     <= irq_d;
        end
    end

    assign rd_count = (32'(rd_ch) < NUM_CH) ? count_q[rd_ch] : '0;
    assign timeout  = timeout_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_cdtimer_multi.sv
// Directed bench for cdtimer_multi: inputs change on the falling edge, outputs
// are sampled on the falling edge after each rising edge.
module tb_cdtimer_multi;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned WIDTH       = 16;
    localparam int unsigned PRESC_WIDTH = 16;
    localparam int unsigned CH_W        = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [PRESC_WIDTH-1:0] presc_div;
    logic                   wr;
    logic [CH_W-1:0]        wr_ch;
    logic [WIDTH-1:0]       wr_data;
    logic                   wr_auto;
    logic [NUM_CH-1:0]      run;
    logic [NUM_CH-1:0]      clr_timeout;
    logic [NUM_CH-1:0]      irq_en;
    logic [CH_W-1:0]        rd_ch;
    logic [WIDTH-1:0]       rd_count;
    logic [NUM_CH-1:0]      timeout;
    logic                   irq;

    int checks = 0;
    int fails  = 0;

    cdtimer_multi #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESC_WIDTH(PRESC_WIDTH), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst), .presc_div(presc_div), .wr(wr), .wr_ch(wr_ch),
        .wr_data(wr_data), .wr_auto(wr_auto), .run(run), .clr_timeout(clr_timeout),
        .irq_en(irq_en), .rd_ch(rd_ch), .rd_count(rd_count), .timeout(timeout),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int ch, input int data, input logic auto_mode);
        wr      = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_data = WIDTH'(data);
        wr_auto = auto_mode;
        step();
        wr      = 1'b0;
    endtask

    initial begin
        int seq_a [7];
        seq_a = '{2, 2, 2, 1, 1, 1, 0};
        rst = 1'b0; presc_div = '0; wr = 1'b0; wr_ch = '0; wr_data = '0;
        wr_auto = 1'b0; run = '0; clr_timeout = '0; irq_en = '0; rd_ch = '0;
        #12;
        chk("rst_count", 32'(rd_count), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_irq", 32'(irq), 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // One-shot ch0=2 at P=2
        presc_div = 16'd2; run = 4'b0001; rd_ch = 2'd0;
        do_write(0, 2, 1'b0);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("oneshot_cnt%0d", k), 32'(rd_count), 32'(seq_a[k]));
            chk($sformatf("oneshot_to%0d", k), 32'(timeout[0]), (k == 6) ? 1 : 0);
            if (k < 6) step();
        end
        chk("oneshot_irq_masked", 32'(irq), 0);
        repeat (6) step();
        chk("oneshot_hold_cnt", 32'(rd_count), 0);
        chk("oneshot_hold_to", 32'(timeout[0]), 1);

        // Auto-reload ch1=3 at P=0 with clear vs. expiry race
        presc_div = 16'd0; run = 4'b0011; rd_ch = 2'd1;
        do_write(1, 3, 1'b1);
        chk("auto_c3", 32'(rd_count), 3);
        chk("auto_to_init", 32'(timeout[1]), 0);
        step(); chk("auto_c2", 32'(rd_count), 2);
        step(); chk("auto_c1", 32'(rd_count), 1);
        chk("auto_to_pre", 32'(timeout[1]), 0);
        step(); chk("auto_reload", 32'(rd_count), 3);
        chk("auto_to_set", 32'(timeout[1]), 1);
        step(); step();
        chk("auto_c1b", 32'(rd_count), 1);
        clr_timeout = 4'b0010;
        step();
        clr_timeout = 4'b0000;
        chk("clr_race_cnt", 32'(rd_count), 3);
        chk("clr_race_to", 32'(timeout[1]), 1);
        step(); chk("auto_to_hold", 32'(timeout[1]), 1);
        clr_timeout = 4'b0010;
        step();
        clr_timeout = 4'b0000;
        chk("clr_quiet_cnt", 32'(rd_count), 1);
        chk("clr_quiet_to", 32'(timeout[1]), 0);
        step(); chk("auto_reexpire", 32'(timeout[1]), 1);
        run = 4'b0001; clr_timeout = 4'b0010;
        step();
        clr_timeout = 4'b0000;
        chk("clr_while_stopped", 32'(timeout[1]), 0);
        chk("stopped_hold", 32'(rd_count), 3);

        // Reload mid-period on ch0 at P=2
        presc_div = 16'd2; rd_ch = 2'd0;
        do_write(0, 5, 1'b0);
        chk("midp_c5", 32'(rd_count), 5);
        chk("midp_to_clr", 32'(timeout[0]), 0);
        step();
        do_write(0, 10, 1'b0);
        chk("midp_c10a", 32'(rd_count), 10);
        step(); chk("midp_c10b", 32'(rd_count), 10);
        step(); chk("midp_c10c", 32'(rd_count), 10);
        step(); chk("midp_c9", 32'(rd_count), 9);
        run = 4'b0000;

        // Zero write clears timeout and never fires
        presc_div = 16'd0; run = 4'b0100; rd_ch = 2'd2;
        do_write(2, 1, 1'b0);
        chk("zero_c1", 32'(rd_count), 1);
        step();
        chk("zero_expire_cnt", 32'(rd_count), 0);
        chk("zero_expire_to", 32'(timeout[2]), 1);
        do_write(2, 0, 1'b1);
        chk("zero_wr_to", 32'(timeout[2]), 0);
        presc_div = 16'd1;
        repeat (5) step();
        chk("zero_idle_cnt", 32'(rd_count), 0);
        chk("zero_idle_to", 32'(timeout[2]), 0);

        // Isolation and gating: ch0 runs, ch3 held, only ch3 unmasked
        run = 4'b0001; irq_en = 4'b1000; rd_ch = 2'd3;
        do_write(0, 4, 1'b0);
        do_write(3, 4, 1'b0);
        repeat (6) step();
        chk("iso_ch0_pre", 32'(timeout[0]), 0);
        step();
        chk("iso_ch0_to", 32'(timeout[0]), 1);
        chk("iso_ch3_hold", 32'(rd_count), 4);
        chk("iso_ch3_to", 32'(timeout[3]), 0);
        chk("iso_irq_masked", 32'(irq), 0);
        run = 4'b1001;
        step();
        chk("gate_first", 32'(rd_count), 4);
        run = 4'b0001;
        repeat (3) step();
        chk("gate_held", 32'(rd_count), 4);
        run = 4'b1001;
        step();
        chk("gate_resume", 32'(rd_count), 3);
        repeat (5) step();
        chk("ch3_pre_cnt", 32'(rd_count), 1);
        chk("ch3_pre_irq", 32'(irq), 0);
        step();
        chk("ch3_exp_cnt", 32'(rd_count), 0);
        chk("ch3_exp_to", 32'(timeout[3]), 1);
        chk("ch3_exp_irq", 32'(irq), 1);
        irq_en = 4'b0000;
        step();
        chk("irq_masked_off", 32'(irq), 0);

        // Asynchronous reset mid-count
        irq_en = 4'b1000;
        step();
        chk("irq_reenable", 32'(irq), 1);
        presc_div = 16'd2; run = 4'b0001; rd_ch = 2'd0;
        do_write(0, 5, 1'b0);
        step();
        chk("prerst_cnt", 32'(rd_count), 5);
        rst = 1'b0;
        #1;
        chk("arst_cnt", 32'(rd_count), 0);
        chk("arst_to", 32'(timeout), 0);
        chk("arst_irq", 32'(irq), 0);
        step(); step();
        rd_ch = 2'd3;
        #1;
        chk("arst_ch3", 32'(rd_count), 0);
        @(negedge clk);
        rst = 1'b1; rd_ch = 2'd0;
        repeat (3) step();
        chk("post_rst_cnt", 32'(rd_count), 0);
        chk("post_rst_to", 32'(timeout), 0);
        chk("post_rst_irq", 32'(irq), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
